frame_burst_writer: RTL



---
 rtl/frame_burst_writer_pkg.sv | 22 ++
 rtl/frame_burst_writer_pix_fifo.sv | 88 ++++++++
 rtl/frame_burst_writer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/frame_burst_writer_pkg.sv
// -----------------------------------------------------------------------------
// frame_burst_writer_pkg
// Shared definitions for the frame burst writer: write-path FSM state
// encoding, frame-buffer address width and the frame size helper.
// -----------------------------------------------------------------------------
package frame_burst_writer_pkg;

    // Word address width of the SDRAM frame-buffer controller.
    localparam int ADDR_W = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } fbw_state_t;

    // One pixel occupies one word, so a frame is simply H*V words.
    function automatic int frame_words(input int h_active, input int v_active);
        return h_active * v_active;
    endfunction

endpackage

// File: rtl/frame_burst_writer_pix_fifo.sv
// -----------------------------------------------------------------------------
// frame_burst_writer_pix_fifo
// Synchronous pixel FIFO between the unthrottled pixel stream and the burst
// engine. Read data is registered: a pop loads o_rd_data at the clock edge,
// so the popped word is visible the cycle after the pop.
// A push while full is dropped even if a pop happens in the same cycle;
// fullness is judged on the current count.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_push       write strobe (ignored while full)
//   i_push_data  word to write
//   i_pop        read strobe (ignored while empty)
//   o_rd_data    registered read word, 0 after reset
//   o_count      number of stored words (0..DEPTH)
//   o_full       count == DEPTH
// -----------------------------------------------------------------------------
module frame_burst_writer_pix_fifo #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 64,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [CW-1:0]     o_count,
    output logic              o_full
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_rd_data;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are valid, and a resettable array would cost a reset
    // net per bit for nothing.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // NOTE: every state register is written with <= so all flops sample the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr];
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_count   = r_count;
    assign o_full    = w_full;

endmodule

// File: rtl/frame_burst_writer.sv
// -----------------------------------------------------------------------------
// frame_burst_writer
// Buffers the in-order RGB565 pixel stream and writes it to the SDRAM frame
// buffer as fixed-length bursts at linearly advancing word addresses. The
// pixel stream has no backpressure: pixels arriving while the FIFO is full
// are dropped and flagged by a sticky overflow.
//
// Burst sequence: IDLE waits for BURST_LEN buffered words, REQ holds wr_req
// with a stable address until wr_ack, DATA streams BURST_LEN words on
// consecutive cycles. The first pop happens on the ack edge so data follows
// the ack by exactly one cycle.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   pix_data        16-bit pixel, pix_valid strobe (no backpressure)
//   wr_req/wr_addr  burst request and start word address
//   wr_ack          one-cycle accept from the controller (only used in REQ)
//   wr_data/_valid  burst words, one per cycle
//   frame_done      one-cycle pulse after the last word of a frame
//   overflow        sticky, a pixel was dropped
//   frame_sel       frame buffer currently being written
//
// Build option: define FRAME_DOUBLE_BUFFER_EN to alternate frames between
// offset 0 and offset FRAME_WORDS; otherwise frame_sel is tied low.
// -----------------------------------------------------------------------------
module frame_burst_writer
    import frame_burst_writer_pkg::*;
#(
    parameter int                H_ACTIVE   = 640,
    parameter int                V_ACTIVE   = 480,
    parameter int                BURST_LEN  = 16,
    parameter int                FIFO_DEPTH = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       pix_data,
    input  logic              pix_valid,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_ack,
    output logic [15:0]       wr_data,
    output logic              wr_data_valid,
    output logic              frame_done,
    output logic              overflow,
    output logic              frame_sel
);

    localparam int FRAME_WORDS = frame_words(H_ACTIVE, V_ACTIVE);
    localparam int BW          = $clog2(BURST_LEN);
    localparam int CW          = $clog2(FIFO_DEPTH) + 1;

    // Elaboration-time parameter checks.
    if ((FRAME_WORDS % BURST_LEN) != 0) begin : g_bad_frame
        $error("frame_burst_writer: H_ACTIVE*V_ACTIVE must be a multiple of BURST_LEN");
    end
    if ((BURST_LEN < 2) || ((BURST_LEN & (BURST_LEN - 1)) != 0)) begin : g_bad_burst
        $error("frame_burst_writer: BURST_LEN must be a power of two >= 2");
    end
    if ((FIFO_DEPTH < 2 * BURST_LEN) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("frame_burst_writer: FIFO_DEPTH must be a power of two >= 2*BURST_LEN");
    end

    fbw_state_t        r_state;
    fbw_state_t        w_state_next;
    logic [BW-1:0]     r_beat;
    logic [ADDR_W-1:0] r_word_ptr;
    logic              r_wr_data_valid;
    logic              r_frame_done;
    logic              r_overflow;

    logic              w_pop;
    logic              w_burst_done;
    logic              w_last_beat;
    logic              w_wrap;
    logic [ADDR_W-1:0] w_ptr_next;
    logic [ADDR_W-1:0] w_frame_offset;
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic [15:0]       w_fifo_data;

    frame_burst_writer_pix_fifo #(
        .DATA_W (16),
        .DEPTH  (FIFO_DEPTH)
    ) u_pix_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (pix_valid),
        .i_push_data (pix_data),
        .i_pop       (w_pop),
        .o_rd_data   (w_fifo_data),
        .o_count     (w_count),
        .o_full      (w_full)
    );

    assign w_last_beat = (r_beat == BW'(BURST_LEN - 1));
    assign w_ptr_next  = r_word_ptr + ADDR_W'(BURST_LEN);
    assign w_wrap      = (w_ptr_next == ADDR_W'(FRAME_WORDS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_burst_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_count >= CW'(BURST_LEN)) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (wr_ack) begin
                    w_state_next = ST_DATA;
                    w_pop        = 1'b1;
                end
            end
            ST_DATA: begin
                // Pops run one beat ahead of the output: the ack edge plus
                // beats 0..BURST_LEN-2 give exactly BURST_LEN pops.
                if (w_last_beat) begin
                    w_state_next = ST_IDLE;
                    w_burst_done = 1'b1;
                end else begin
                    w_pop = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat          <= '0;
            r_word_ptr      <= '0;
            r_wr_data_valid <= 1'b0;
            r_frame_done    <= 1'b0;
            r_overflow      <= 1'b0;
        end else begin
            r_wr_data_valid <= w_pop;
            r_frame_done    <= w_burst_done && w_wrap;
            if (pix_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            if (r_state == ST_DATA) begin
                r_beat <= r_beat + 1'b1;
            end else begin
                r_beat <= '0;
            end
            if (w_burst_done) begin
                r_word_ptr <= w_wrap ? '0 : w_ptr_next;
            end
        end
    end

`ifdef FRAME_DOUBLE_BUFFER_EN
    if ((2 * FRAME_WORDS + int'(BASE_ADDR)) > (1 << ADDR_W)) begin : g_bad_addr
        $error("frame_burst_writer: two frames above BASE_ADDR exceed the address space");
    end

    logic r_frame_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_sel <= 1'b0;
        end else if (w_burst_done && w_wrap) begin
            r_frame_sel <= ~r_frame_sel;
        end
    end

    assign w_frame_offset = r_frame_sel ? ADDR_W'(FRAME_WORDS) : '0;
    assign frame_sel      = r_frame_sel;
`else
    if ((FRAME_WORDS + int'(BASE_ADDR)) > (1 << ADDR_W)) begin : g_bad_addr
        $error("frame_burst_writer: frame above BASE_ADDR exceeds the address space");
    end

    assign w_frame_offset = '0;
    assign frame_sel      = 1'b0;
`endif

    // Address sources only change at the end of a burst, so wr_addr is
    // stable for the whole time wr_req is high.
    assign wr_req        = (r_state == ST_REQ);
    assign wr_addr       = BASE_ADDR + w_frame_offset + r_word_ptr;
    assign wr_data       = w_fifo_data;
    assign wr_data_valid = r_wr_data_valid;
    assign frame_done    = r_frame_done;
    assign overflow      = r_overflow;

endmodule
